// File: rtl/key_step_gen_pkg.sv
// Shared definitions for the key step generator: FSM state encoding,
// synchroniser reset level and a small sizing helper.
package key_step_gen_pkg;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      PRESS_DEB   = 3'd1,
      HELD_WAIT   = 3'd2,
      REPEAT      = 3'd3,
      RELEASE_DEB = 3'd4
   } state_t;

   // Inactive key level after polarity normalisation.
   localparam logic SYNC_RST_LVL = 1'b0;

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/key_step_gen_sync.sv
// Parameterised 2-flop synchroniser with asynchronous active-low reset,
// shared by all push-button inputs.
module key_sync #(
   parameter int unsigned      WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/key_step_gen.sv
// Debounces a raw push-button into single-cycle step strobes with optional
// auto-repeat while held, plus an 8-bit strobe counter for debug display.
module key_step_gen
   import key_step_gen_pkg::*;
#(
   parameter int unsigned DEB_CYCLES     = 500000,
   parameter int unsigned HOLD_CYCLES    = 25000000,
   parameter int unsigned REPEAT_CYCLES  = 5000000,
   parameter int unsigned REPEAT_EN      = 1,
   parameter int unsigned KEY_ACTIVE_LOW = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_in,
   output logic       step,
   output logic       key_level,
   output logic       repeating,
   output logic [7:0] step_cnt
);

   localparam int unsigned CNT_MAX = max3(DEB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
   localparam int unsigned CNT_W   = $clog2(CNT_MAX);

   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic w_key_norm;
   logic w_key_s;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_step;
   logic             r_key_level;
   logic             r_repeating;
   logic [7:0]       r_step_cnt;

   assign w_key_norm = (KEY_ACTIVE_LOW != 0) ? ~key_in : key_in;

   key_sync #(
      .WIDTH   (1),
      .RST_VAL (SYNC_RST_LVL)
   ) u_key_sync (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_d     (w_key_norm),
      .o_q     (w_key_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_step      <= 1'b0;
         r_key_level <= 1'b0;
         r_repeating <= 1'b0;
         r_step_cnt  <= '0;
      end else begin
         r_step <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_key_s) begin
                  r_state <= PRESS_DEB;
                  r_cnt   <= '0;
               end
            end
            PRESS_DEB: begin
               if (!w_key_s) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else if (r_cnt == DEB_LAST) begin
                  r_state     <= HELD_WAIT;
                  r_cnt       <= '0;
                  r_step      <= 1'b1;
                  r_step_cnt  <= r_step_cnt + 8'd1;
                  r_key_level <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            HELD_WAIT: begin
               if (!w_key_s) begin
                  r_state <= RELEASE_DEB;
                  r_cnt   <= '0;
               end else if (r_cnt == HOLD_LAST) begin
                  // Without auto-repeat the timer simply parks at its last value.
                  if (REPEAT_EN != 0) begin
                     r_state     <= REPEAT;
                     r_cnt       <= '0;
                     r_step      <= 1'b1;
                     r_step_cnt  <= r_step_cnt + 8'd1;
                     r_repeating <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            REPEAT: begin
               // Release is checked first so it beats a coincident repeat expiry.
               if (!w_key_s) begin
                  r_state     <= RELEASE_DEB;
                  r_cnt       <= '0;
                  r_repeating <= 1'b0;
               end else if (r_cnt == REP_LAST) begin
                  r_cnt      <= '0;
                  r_step     <= 1'b1;
                  r_step_cnt <= r_step_cnt + 8'd1;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            RELEASE_DEB: begin
               if (w_key_s) begin
                  r_state <= HELD_WAIT;
                  r_cnt   <= '0;
               end else if (r_cnt == DEB_LAST) begin
                  r_state     <= IDLE;
                  r_cnt       <= '0;
                  r_key_level <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign step      = r_step;
   assign key_level = r_key_level;
   assign repeating = r_repeating;
   assign step_cnt  = r_step_cnt;

endmodule

// File: tb/tb_key_step_gen.sv
// Scoreboard bench for key_step_gen: a run-length reference model predicts
// strobes and levels; a negedge monitor compares against the DUT.
module tb_key_step_gen;

   localparam int DEB  = 4;
   localparam int HOLD = 16;
   localparam int REP  = 8;

   logic       clk;
   logic       rst_n;
   logic       key_in;
   logic       step;
   logic       key_level;
   logic       repeating;
   logic [7:0] step_cnt;

   key_step_gen #(
      .DEB_CYCLES     (DEB),
      .HOLD_CYCLES    (HOLD),
      .REPEAT_CYCLES  (REP),
      .REPEAT_EN      (1),
      .KEY_ACTIVE_LOW (0)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_in    (key_in),
      .step      (step),
      .key_level (key_level),
      .repeating (repeating),
      .step_cnt  (step_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      int cnt;
   } ev_t;

   ev_t q[$];

   int total = 0;
   int bad   = 0;
   int dut_strobes = 0;

   // Reference model state
   int cyc = 0;
   int d1 = 0, d2 = 0;
   int ones = 0, zeros = 0, t = 0;
   int exp_lvl = 0, exp_rep = 0, exp_cnt = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: key_s is key_in delayed two edges; a level flips after DEB+1
   // consecutive opposite samples; repeats are timed from the hold anchor.
   initial begin
      int s;
      ev_t e;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            d1 = 0; d2 = 0; ones = 0; zeros = 0; t = 0;
            exp_lvl = 0; exp_rep = 0; exp_cnt = 0;
            q.delete();
         end else begin
            cyc++;
            s  = d2;
            d2 = d1;
            d1 = int'(key_in);
            if (exp_lvl == 0) begin
               ones = s ? ones + 1 : 0;
               if (ones == DEB + 1) begin
                  exp_lvl = 1; zeros = 0; t = 0; exp_rep = 0;
                  exp_cnt = (exp_cnt + 1) % 256;
                  e.cyc = cyc; e.cnt = exp_cnt; q.push_back(e);
               end
            end else if (s == 0) begin
               zeros++;
               exp_rep = 0;
               if (zeros == DEB + 1) begin
                  exp_lvl = 0; ones = 0;
               end
            end else if (zeros > 0) begin
               zeros = 0; t = 0;
            end else begin
               t++;
               if (t == HOLD || (t > HOLD && (t - HOLD) % REP == 0)) begin
                  exp_rep = 1;
                  exp_cnt = (exp_cnt + 1) % 256;
                  e.cyc = cyc; e.cnt = exp_cnt; q.push_back(e);
               end
            end
         end
      end
   end

   // Monitor
   initial begin
      ev_t e;
      forever begin
         @(negedge clk);
         chk("key_level", int'(key_level), exp_lvl);
         chk("repeating", int'(repeating), exp_rep);
         chk("step_cnt", int'(step_cnt), exp_cnt);
         if (step) begin
            dut_strobes++;
            if (q.size() == 0) begin
               chk("step_unexpected", int'(step), 0);
            end else begin
               e = q.pop_front();
               chk("step_cycle", cyc, e.cyc);
               chk("step_cnt_at_step", int'(step_cnt), e.cnt);
            end
         end else if (q.size() != 0 && q[0].cyc <= cyc) begin
            chk("step_missed", int'(step), 1);
            void'(q.pop_front());
         end
      end
   end

   task automatic seg(input logic v, input int n);
      key_in = v;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int base;
      int n;
      rst_n  = 1'b0;
      key_in = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_step", int'(step), 0);
      chk("rst_key_level", int'(key_level), 0);
      chk("rst_repeating", int'(repeating), 0);
      chk("rst_step_cnt", int'(step_cnt), 0);
      rst_n = 1'b1;

      // Clean press
      base = dut_strobes;
      seg(1'b1, 12); seg(1'b0, 12); #1;
      chk("t1_strobes", dut_strobes - base, 1);
      chk("t1_cnt", int'(step_cnt), 1);

      // Press bounce
      base = dut_strobes;
      seg(1'b1, 2); seg(1'b0, 1); seg(1'b1, 3); seg(1'b0, 12); #1;
      chk("t2_strobes", dut_strobes - base, 0);
      chk("t2_cnt", int'(step_cnt), 1);

      // Long hold with auto-repeat
      base = dut_strobes;
      seg(1'b1, 67); seg(1'b0, 12); #1;
      chk("t3_strobes", dut_strobes - base, 7);
      chk("t3_cnt", int'(step_cnt), 8);
      chk("t3_repeating", int'(repeating), 0);

      // Release bounce
      base = dut_strobes;
      seg(1'b1, 12); seg(1'b0, 2); seg(1'b1, 1); seg(1'b0, 12); #1;
      chk("t4_strobes", dut_strobes - base, 1);
      chk("t4_key_level", int'(key_level), 0);

      // Counter wrap from a fresh reset
      rst_n = 1'b0;
      @(negedge clk); #1;
      rst_n = 1'b1;
      base = dut_strobes;
      for (int i = 0; i < 256; i++) begin
         seg(1'b1, 8); seg(1'b0, 8);
      end
      #1;
      chk("t5_strobes", dut_strobes - base, 256);
      chk("t5_cnt", int'(step_cnt), 0);

      // Reset in the middle of auto-repeat
      seg(1'b1, 37);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_step", int'(step), 0);
      chk("t6_rst_key_level", int'(key_level), 0);
      chk("t6_rst_repeating", int'(repeating), 0);
      chk("t6_rst_step_cnt", int'(step_cnt), 0);
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk); #1;
         if (step) begin
            n = i;
            break;
         end
      end
      chk("t6_latency", n, DEB + 3);
      chk("t6_cnt", int'(step_cnt), 1);
      seg(1'b0, 12);

      // Random segments
      for (int i = 0; i < 200; i++) begin
         int len;
         len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(20, 60))
                                           : int'($urandom_range(1, 10));
         seg(1'(($urandom_range(0, 1))), len);
      end
      seg(1'b0, 15); #1;
      chk("queue_empty", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
